// File: rtl/core_run_ctrl.sv
// Run/step/halt sequencer that drives the enable and reset of a single-cycle core.
// Optional breakpoint support is compiled in with `define CORE_RUN_CTRL_BREAKPOINT_EN.
module core_run_ctrl #(
    parameter int PC_W    = 9,
    parameter int STEP_W  = 8,
    parameter int CNT_W   = 16,
    parameter int RST_CYC = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              run_i,
    input  logic              step_i,
    input  logic [STEP_W-1:0] step_n_i,
    input  logic              halt_i,
    input  logic              soft_rst_i,
    input  logic [PC_W-1:0]   pc_i,
`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
    input  logic [PC_W-1:0]   bp_addr_i,
    input  logic              bp_valid_i,
    output logic              bp_hit_o,
`endif
    output logic              core_en_o,
    output logic              core_rst_o,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  instr_cnt_o
);

    localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_RESET = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              core_rst_q, core_rst_d;
    logic              active;
    logic              bp_match;
    logic              core_en;

    assign active = (state_q == ST_RUN) || (state_q == ST_STEP);

`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
    logic first_q, first_d;
    logic bp_hit_q, bp_hit_d;

    // Suppressing the match in the first enabled cycle lets a resume step past the breakpoint.
    assign bp_match = bp_valid_i && (pc_i == bp_addr_i) && active && !first_q;
    assign first_d  = !active;

    always_comb begin
        bp_hit_d = bp_hit_q;
        if (soft_rst_i) begin
            bp_hit_d = 1'b0;
        end else if (bp_match && !halt_i) begin
            bp_hit_d = 1'b1;
        end else if (run_i || step_i) begin
            bp_hit_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            first_q  <= 1'b1;
            bp_hit_q <= 1'b0;
        end else begin
            first_q  <= first_d;
            bp_hit_q <= bp_hit_d;
        end
    end

    assign bp_hit_o = bp_hit_q;
`else
    logic unused_pc;
    assign unused_pc = ^pc_i;
    assign bp_match  = 1'b0;
`endif

    assign core_en = active && !bp_match;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        rst_cnt_d = rst_cnt_q;
        cnt_d     = cnt_q;

        if (core_en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (core_en && (state_q == ST_STEP)) begin
            rem_d = rem_q - 1'b1;
        end

        if (soft_rst_i) begin
            state_d   = ST_RESET;
            rst_cnt_d = '0;
            rem_d     = '0;
            cnt_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (halt_i) begin
                        state_d = ST_IDLE;
                    end else if (run_i) begin
                        state_d = ST_RUN;
                    end else if (step_i) begin
                        state_d = ST_STEP;
                        rem_d   = (step_n_i == '0) ? STEP_W'(1) : step_n_i;
                    end
                end
                ST_RUN: begin
                    if (halt_i || bp_match) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_STEP: begin
                    if (halt_i || bp_match) begin
                        state_d = ST_IDLE;
                        rem_d   = '0;
                    end else if (rem_q <= STEP_W'(1)) begin
                        state_d = ST_IDLE;
                        rem_d   = '0;
                    end
                end
                default: begin
                    cnt_d = '0;
                    if (rst_cnt_q == RC_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 1'b1;
                    end
                end
            endcase
        end

        core_rst_d = (state_d == ST_RESET);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            rst_cnt_q  <= '0;
            cnt_q      <= '0;
            core_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            rst_cnt_q  <= rst_cnt_d;
            cnt_q      <= cnt_d;
            core_rst_q <= core_rst_d;
        end
    end

    assign core_en_o   = core_en;
    assign core_rst_o  = core_rst_q;
    assign state_o     = state_q;
    assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench for core_run_ctrl: each run/step/reset episode pushes its expected
// outcome; a monitor closes an episode when the state returns to IDLE and compares.
module tb_core_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run, step, halt, soft_rst;
    logic [7:0]  step_n;
    logic [8:0]  pc;
    logic        en, core_rst;
    logic [1:0]  state;
    logic [15:0] cnt;
    logic        unused_en_s, unused_rst_s;
    logic [1:0]  unused_state_s;
    logic [3:0]  cnt_s;
`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
    logic [8:0]  bp_addr;
    logic        bp_valid;
    logic        bp_hit, unused_bp_hit_s;
`endif

    always #5 clk = ~clk;

    core_run_ctrl dut (
        .clk_i(clk), .rst_i(rst_n), .run_i(run), .step_i(step), .step_n_i(step_n),
        .halt_i(halt), .soft_rst_i(soft_rst), .pc_i(pc),
`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
        .bp_addr_i(bp_addr), .bp_valid_i(bp_valid), .bp_hit_o(bp_hit),
`endif
        .core_en_o(en), .core_rst_o(core_rst), .state_o(state), .instr_cnt_o(cnt)
    );

    core_run_ctrl #(.CNT_W(4)) dut_small (
        .clk_i(clk), .rst_i(rst_n), .run_i(run), .step_i(step), .step_n_i(step_n),
        .halt_i(halt), .soft_rst_i(soft_rst), .pc_i(pc),
`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
        .bp_addr_i(bp_addr), .bp_valid_i(bp_valid), .bp_hit_o(unused_bp_hit_s),
`endif
        .core_en_o(unused_en_s), .core_rst_o(unused_rst_s), .state_o(unused_state_s),
        .instr_cnt_o(cnt_s)
    );

    // Tiny core model: 4-byte instructions, PC cleared by core reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        pc <= '0;
        else if (core_rst) pc <= '0;
        else if (en)       pc <= pc + 9'd4;
    end

    typedef struct {
        int first_state;
        int en_cycles;
        int rst_cycles;
        int cnt;
        int cnt_small;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: counts enabled / core-reset cycles per episode, compares on return to IDLE.
    int mon_en = 0, mon_rst = 0, mon_first = 0;
    logic [1:0] prev_state = 2'b00;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_en = 0; mon_rst = 0; prev_state = 2'b00;
        end else begin
            if (prev_state == 2'b00 && state != 2'b00) begin
                mon_first = int'(state); mon_en = 0; mon_rst = 0;
            end
            if (en)       mon_en++;
            if (core_rst) mon_rst++;
            if (prev_state != 2'b00 && state == 2'b00) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_episode", 1, 0);
                end else begin
                    exp_t  e;
                    string n;
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    chk({n, ".first_state"}, mon_first, e.first_state);
                    chk({n, ".en_cycles"},   mon_en,    e.en_cycles);
                    chk({n, ".rst_cycles"},  mon_rst,   e.rst_cycles);
                    chk({n, ".instr_cnt"},   int'(cnt),   e.cnt);
                    chk({n, ".instr_cnt4"},  int'(cnt_s), e.cnt_small);
                    $display("episode %s: first_state=%0d en=%0d rst=%0d cnt=%0d cnt4=%0d",
                             n, mon_first, mon_en, mon_rst, cnt, cnt_s);
                end
            end
            prev_state = state;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ep(input string n, input int fs, input int e, input int r,
                             input int c, input int cs);
        exp_t x;
        x.first_state = fs; x.en_cycles = e; x.rst_cycles = r; x.cnt = c; x.cnt_small = cs;
        exp_q.push_back(x);
        name_q.push_back(n);
    endtask

    task automatic wait_idle(input string n);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk({n, ".timeout"}, exp_q.size(), 0);
            exp_q.delete();
            name_q.delete();
        end
        cycle();
    endtask

    task automatic pulse_run();
        run = 1'b1; cycle(); run = 1'b0;
    endtask

    task automatic pulse_step(input logic [7:0] n);
        step_n = n; step = 1'b1; cycle(); step = 1'b0;
    endtask

    task automatic pulse_halt();
        halt = 1'b1; cycle(); halt = 1'b0;
    endtask

    task automatic check_reset_vals(input string n);
        chk({n, ".core_en"},   int'(en),       0);
        chk({n, ".core_rst"},  int'(core_rst), 0);
        chk({n, ".state"},     int'(state),    0);
        chk({n, ".instr_cnt"}, int'(cnt),      0);
        chk({n, ".instr_cnt4"}, int'(cnt_s),   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; step = 1'b0; halt = 1'b0; soft_rst = 1'b0; step_n = '0;
`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
        bp_addr = 9'h010; bp_valid = 1'b0;
`endif
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (5) cycle();
        check_reset_vals("por_idle");

        expect_ep("step3", 2, 3, 0, 3, 3);
        pulse_step(8'd3);
        wait_idle("step3");

        expect_ep("step0", 2, 1, 0, 4, 4);
        pulse_step(8'd0);
        wait_idle("step0");

        // halt sampled 11 edges after run: 11 retired
        expect_ep("run11", 1, 11, 0, 15, 15);
        pulse_run();
        repeat (10) cycle();
        pulse_halt();
        wait_idle("run11");

        // soft reset and halt together while running: reset wins
        expect_ep("run_softrst", 1, 4, 2, 0, 0);
        pulse_run();
        repeat (3) cycle();
        soft_rst = 1'b1; halt = 1'b1; cycle(); soft_rst = 1'b0; halt = 1'b0;
        wait_idle("run_softrst");

        expect_ep("run20_sat", 1, 20, 0, 20, 15);
        pulse_run();
        repeat (19) cycle();
        pulse_halt();
        wait_idle("run20_sat");

        expect_ep("step_halt", 2, 3, 0, 23, 15);
        pulse_step(8'd10);
        repeat (2) cycle();
        pulse_halt();
        wait_idle("step_halt");

        // hard reset with 5 steps still remaining
        pulse_step(8'd8);
        repeat (3) cycle();
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst_mid_step");
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();

        expect_ep("step2_after_rst", 2, 2, 0, 2, 2);
        pulse_step(8'd2);
        wait_idle("step2_after_rst");

`ifdef CORE_RUN_CTRL_BREAKPOINT_EN
        expect_ep("softrst_idle", 3, 0, 2, 0, 0);
        soft_rst = 1'b1; cycle(); soft_rst = 1'b0;
        wait_idle("softrst_idle");

        bp_valid = 1'b1;
        expect_ep("run_to_bp", 1, 4, 0, 4, 4);
        pulse_run();
        wait_idle("run_to_bp");
        chk("bp_stop.pc",     int'(pc),     16);
        chk("bp_stop.bp_hit", int'(bp_hit), 1);

        expect_ep("step_past_bp", 2, 1, 0, 5, 5);
        pulse_step(8'd1);
        wait_idle("step_past_bp");
        chk("bp_resume.pc",     int'(pc),     20);
        chk("bp_resume.bp_hit", int'(bp_hit), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
